// File: rtl/register_bus_pkg.sv
// Shared types and constants for the register W/R bus initiator.
// The command struct describes one FIFO entry at the default bus widths.
package register_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic OP_WRITE = 1'b0;
   localparam logic OP_READ  = 1'b1;

   localparam int DEFAULT_ADDR_WIDTH  = 33;
   localparam int DEFAULT_WDATA_WIDTH = 33;
   localparam int DEFAULT_RDATA_WIDTH = 21;

   typedef struct packed {
      logic                           is_read;
      logic [DEFAULT_ADDR_WIDTH-1:0]  addr;
      logic [DEFAULT_WDATA_WIDTH-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/register_bus_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head word is visible
// combinationally on dout whenever the FIFO is non-empty.
module register_bus_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 67
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LEVEL);
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // NOTE: storage has no reset; validity is tracked by level, and leaving
   // the array out of the reset network keeps it mappable to plain RAM.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // flop samples the pre-edge value regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/register_bus_master.sv
// Register W/R bus initiator: queues commands, issues them in order on the
// bus and returns read results through a valid/ready response port.
module register_bus_master
   import register_bus_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int WDATA_WIDTH  = DEFAULT_WDATA_WIDTH,
   parameter int RDATA_WIDTH  = DEFAULT_RDATA_WIDTH,
   parameter int FIFO_DEPTH   = 4,
   parameter int READ_LATENCY = 0
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_is_read,
   input  logic [ADDR_WIDTH-1:0]         cmd_addr,
   input  logic [WDATA_WIDTH-1:0]        cmd_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ADDR_WIDTH-1:0]         rsp_addr,
   output logic [RDATA_WIDTH-1:0]        rsp_rdata,
   output logic [ADDR_WIDTH-1:0]         address,
   output logic                          write_enable,
   output logic [WDATA_WIDTH-1:0]        write_data,
   output logic                          read_enable,
   input  logic [RDATA_WIDTH-1:0]        read_data,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   cmd_level
);

   localparam int         CMD_WIDTH = 1 + ADDR_WIDTH + WDATA_WIDTH;
   localparam logic [2:0] LAT       = 3'(READ_LATENCY);

   logic [CMD_WIDTH-1:0]   head;
   logic                   head_is_read;
   logic [ADDR_WIDTH-1:0]  head_addr;
   logic [WDATA_WIDTH-1:0] head_wdata;
   logic                   full;
   logic                   empty;
   logic                   pop;

   state_t                 state, state_nxt;
   logic [ADDR_WIDTH-1:0]  address_nxt, rsp_addr_nxt;
   logic [WDATA_WIDTH-1:0] write_data_nxt;
   logic [RDATA_WIDTH-1:0] rsp_rdata_nxt;
   logic                   write_enable_nxt, read_enable_nxt;
   logic [2:0]             lat_cnt, lat_cnt_nxt;
   logic                   load_head;
   logic                   capture;

   assign {head_is_read, head_addr, head_wdata} = head;

   register_bus_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_WIDTH)
   ) u_cmd_fifo (
      .clock (clock),
      .reset (reset),
      .push  (cmd_valid),
      .pop   (pop),
      .din   ({cmd_is_read, cmd_addr, cmd_wdata}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (cmd_level)
   );

   assign cmd_ready = !full;
   assign rsp_valid = (state == ST_RESP);
   assign busy      = !empty || (state != ST_IDLE);

   // NOTE: every signal written below gets its hold value first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt        = state;
      address_nxt      = address;
      write_data_nxt   = write_data;
      write_enable_nxt = write_enable;
      read_enable_nxt  = read_enable;
      rsp_addr_nxt     = rsp_addr;
      rsp_rdata_nxt    = rsp_rdata;
      lat_cnt_nxt      = lat_cnt;
      load_head        = 1'b0;
      capture          = 1'b0;
      pop              = 1'b0;

      case (state)
         ST_IDLE: load_head = !empty;
         ST_ISSUE: begin
            if (write_enable) begin
               if (!empty) begin
                  load_head = 1'b1;
               end else begin
                  write_enable_nxt = 1'b0;
                  state_nxt        = ST_IDLE;
               end
            end else if (READ_LATENCY == 0) begin
               capture = 1'b1;
            end else begin
               lat_cnt_nxt = LAT;
               state_nxt   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            lat_cnt_nxt = lat_cnt - 3'd1;
            capture     = (lat_cnt == 3'd1);
         end
         ST_RESP: begin
            if (rsp_ready) begin
               if (!empty) load_head = 1'b1;
               else        state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (capture) begin
         rsp_addr_nxt    = address;
         rsp_rdata_nxt   = read_data;
         read_enable_nxt = 1'b0;
         state_nxt       = ST_RESP;
      end

      // The write strobe from the previous ISSUE cycle is replaced, never
      // merged, so only one strobe is ever set.
      if (load_head) begin
         pop              = 1'b1;
         address_nxt      = head_addr;
         write_data_nxt   = head_wdata;
         write_enable_nxt = (head_is_read == OP_WRITE);
         read_enable_nxt  = (head_is_read == OP_READ);
         state_nxt        = ST_ISSUE;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         address      <= '0;
         write_data   <= '0;
         write_enable <= 1'b0;
         read_enable  <= 1'b0;
         rsp_addr     <= '0;
         rsp_rdata    <= '0;
         lat_cnt      <= '0;
      end else begin
         state        <= state_nxt;
         address      <= address_nxt;
         write_data   <= write_data_nxt;
         write_enable <= write_enable_nxt;
         read_enable  <= read_enable_nxt;
         rsp_addr     <= rsp_addr_nxt;
         rsp_rdata    <= rsp_rdata_nxt;
         lat_cnt      <= lat_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_register_bus_master.sv
// Bench for register_bus_master: one instance with combinational-read timing,
// one with two extra read cycles, each behind a small register-file responder.
module tb_register_bus_master;
   import register_bus_pkg::*;

   typedef struct packed {
      logic        we;
      logic        re;
      logic [32:0] addr;
      logic [32:0] wdata;
      logic        rv;
      logic [32:0] raddr;
      logic [20:0] rdata;
      logic [2:0]  lvl;
      logic        busy;
      logic        rdy;
   } obs_t;

   typedef struct packed {
      logic        cv;
      logic        ir;
      logic [32:0] a;
      logic [32:0] wd;
      logic        rr;
      logic [20:0] rd;
      obs_t        exp;
   } vec_t;

   typedef struct packed {
      logic [32:0] addr;
      logic [20:0] data;
   } rsp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic cmd_valid [2], cmd_is_read [2], rsp_ready [2];
   logic cmd_ready [2], rsp_valid [2], write_enable [2], read_enable [2], busy [2];
   logic [32:0] cmd_addr [2], cmd_wdata [2], rsp_addr [2], address [2], write_data [2];
   logic [20:0] rsp_rdata [2], read_data [2], tb_rdata [2];
   logic [2:0]  cmd_level [2];
   logic        auto_rsp = 1'b0;

   int checks = 0;
   int errors = 0;

   cmd_t        bq [$];
   rsp_t        rq [$];
   logic [20:0] mdl [16];
   logic        prev_re;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = g * 2;
      logic [20:0] rmem [16];
      logic [3:0]  re_cnt;
      logic [20:0] junk;

      register_bus_master #(.READ_LATENCY(LAT)) dut (
         .clock        (clock),
         .reset        (reset),
         .cmd_valid    (cmd_valid[g]),
         .cmd_ready    (cmd_ready[g]),
         .cmd_is_read  (cmd_is_read[g]),
         .cmd_addr     (cmd_addr[g]),
         .cmd_wdata    (cmd_wdata[g]),
         .rsp_valid    (rsp_valid[g]),
         .rsp_ready    (rsp_ready[g]),
         .rsp_addr     (rsp_addr[g]),
         .rsp_rdata    (rsp_rdata[g]),
         .address      (address[g]),
         .write_enable (write_enable[g]),
         .write_data   (write_data[g]),
         .read_enable  (read_enable[g]),
         .read_data    (read_data[g]),
         .busy         (busy[g]),
         .cmd_level    (cmd_level[g])
      );

      // Responder: valid data only on the cycle the master should sample it.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            re_cnt <= '0;
            junk   <= '0;
            for (int i = 0; i < 16; i++) rmem[i] <= '0;
         end else begin
            junk   <= 21'($urandom());
            re_cnt <= read_enable[g] ? re_cnt + 4'd1 : 4'd0;
            if (write_enable[g]) rmem[address[g][3:0]] <= write_data[g][20:0];
         end
      end

      assign read_data[g] = !auto_rsp ? tb_rdata[g] :
                            (read_enable[g] && re_cnt == 4'(LAT)) ? rmem[address[g][3:0]] : junk;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic obs_t sample(input int g);
      return {write_enable[g], read_enable[g], address[g], write_data[g], rsp_valid[g],
              rsp_addr[g], rsp_rdata[g], cmd_level[g], busy[g], cmd_ready[g]};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push_cmd(input int g, input logic rd, input logic [32:0] a, input logic [32:0] d);
      cmd_valid[g]   = 1'b1;
      cmd_is_read[g] = rd;
      cmd_addr[g]    = a;
      cmd_wdata[g]   = d;
      tick();
      cmd_valid[g]   = 1'b0;
   endtask

   task automatic wait_rsp(input int g, input string name);
      int n = 0;
      while (!rsp_valid[g] && n < 30) begin
         tick();
         n++;
      end
      check({name, " response timeout"}, 128'(rsp_valid[g]), 128'(1));
   endtask

   task automatic wait_idle(input int g, input string name);
      int n = 0;
      while (busy[g] && n < 40) begin
         tick();
         n++;
      end
      check({name, " drain timeout"}, 128'(busy[g]), 128'(0));
   endtask

   // One cycle of transaction-level monitoring plus random (or draining) drive.
   task automatic random_cycle(input int g, input logic drain);
      cmd_t  e;
      rsp_t  r;
      logic  rd;
      logic [32:0] a, d;
      check("strobe exclusivity", 128'(write_enable[g] && read_enable[g]), 128'(0));
      if (write_enable[g] || (read_enable[g] && !prev_re)) begin
         if (bq.size() == 0) begin
            check("unexpected bus op", 128'(1), 128'(0));
         end else begin
            e = bq.pop_front();
            if (write_enable[g]) check("bus write", {1'b0, address[g], write_data[g]}, e);
            else                 check("bus read", {1'b1, address[g]}, {e.is_read, e.addr});
         end
      end
      prev_re = read_enable[g];
      rsp_ready[g] = drain || ($urandom_range(3, 0) != 0);
      if (rsp_valid[g] && rsp_ready[g]) begin
         if (rq.size() == 0) begin
            check("unexpected response", 128'(1), 128'(0));
         end else begin
            r = rq.pop_front();
            check("read response", {rsp_addr[g], rsp_rdata[g]}, r);
         end
      end
      cmd_valid[g] = 1'b0;
      if (!drain && cmd_ready[g] && $urandom_range(1, 0) == 1) begin
         rd = ($urandom_range(2, 0) == 0);
         a  = {1'($urandom_range(1, 0)), 32'($urandom())};
         d  = {1'($urandom_range(1, 0)), 32'($urandom())};
         cmd_valid[g] = 1'b1;  cmd_is_read[g] = rd;  cmd_addr[g] = a;  cmd_wdata[g] = d;
         bq.push_back('{rd, a, d});
         if (rd) rq.push_back('{a, mdl[a[3:0]]});
         else    mdl[a[3:0]] = d[20:0];
      end
      tick();
   endtask

   task automatic run_random(input int g, input int cycles);
      int n = 0;
      bq.delete();
      rq.delete();
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      prev_re = 1'b0;
      for (int c = 0; c < cycles; c++) random_cycle(g, 1'b0);
      while ((busy[g] || rq.size() != 0) && n < 300) begin
         random_cycle(g, 1'b1);
         n++;
      end
      check("random drain bus queue", 128'(bq.size()), 128'(0));
      check("random drain rsp queue", 128'(rq.size()), 128'(0));
      check("random drain busy", 128'(busy[g]), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [9];
      obs_t snap;
      int   re_first, rv_first, re_cycles;

      for (int g = 0; g < 2; g++) begin
         cmd_valid[g] = 1'b0;  cmd_is_read[g] = 1'b0;  cmd_addr[g] = '0;
         cmd_wdata[g] = '0;    rsp_ready[g] = 1'b1;    tb_rdata[g] = '0;
      end

      // Write burst then a combinational read with a two-cycle response stall.
      vecs[0] = '{1'b1, 1'b0, 33'hAA, 33'h1234, 1'b1, 21'h0, '{1'b0, 1'b0, 33'h0,  33'h0,    1'b0, 33'h0,  21'h0,   3'd1, 1'b1, 1'b1}};
      vecs[1] = '{1'b1, 1'b0, 33'h55, 33'h1,    1'b1, 21'h0, '{1'b1, 1'b0, 33'hAA, 33'h1234, 1'b0, 33'h0,  21'h0,   3'd1, 1'b1, 1'b1}};
      vecs[2] = '{1'b0, 1'b0, 33'h0,  33'h0,    1'b1, 21'h0, '{1'b1, 1'b0, 33'h55, 33'h1,    1'b0, 33'h0,  21'h0,   3'd0, 1'b1, 1'b1}};
      vecs[3] = '{1'b0, 1'b0, 33'h0,  33'h0,    1'b1, 21'h0, '{1'b0, 1'b0, 33'h55, 33'h1,    1'b0, 33'h0,  21'h0,   3'd0, 1'b0, 1'b1}};
      vecs[4] = '{1'b1, 1'b1, 33'hAA, 33'h1,    1'b1, 21'h0, '{1'b0, 1'b0, 33'h55, 33'h1,    1'b0, 33'h0,  21'h0,   3'd1, 1'b1, 1'b1}};
      vecs[5] = '{1'b0, 1'b0, 33'h0,  33'h0,    1'b1, 21'h0, '{1'b0, 1'b1, 33'hAA, 33'h1,    1'b0, 33'h0,  21'h0,   3'd0, 1'b1, 1'b1}};
      vecs[6] = '{1'b0, 1'b0, 33'h0,  33'h0,    1'b0, 21'hABC, '{1'b0, 1'b0, 33'hAA, 33'h1,  1'b1, 33'hAA, 21'hABC, 3'd0, 1'b1, 1'b1}};
      vecs[7] = '{1'b0, 1'b0, 33'h0,  33'h0,    1'b0, 21'h12345, '{1'b0, 1'b0, 33'hAA, 33'h1, 1'b1, 33'hAA, 21'hABC, 3'd0, 1'b1, 1'b1}};
      vecs[8] = '{1'b0, 1'b0, 33'h0,  33'h0,    1'b1, 21'h0, '{1'b0, 1'b0, 33'hAA, 33'h1,    1'b0, 33'hAA, 21'hABC, 3'd0, 1'b0, 1'b1}};

      repeat (3) @(posedge clock);
      #1;
      check("reset state lat0", sample(0), obs_t'({124'h0, 3'd0, 1'b0, 1'b1}));
      check("reset state lat2", sample(1), obs_t'({124'h0, 3'd0, 1'b0, 1'b1}));
      reset = 1'b1;
      tick();
      check("no strobe after release", sample(0), obs_t'({124'h0, 3'd0, 1'b0, 1'b1}));

      for (int i = 0; i < 9; i++) begin
         cmd_valid[0] = vecs[i].cv;  cmd_is_read[0] = vecs[i].ir;  cmd_addr[0] = vecs[i].a;
         cmd_wdata[0] = vecs[i].wd;  rsp_ready[0]   = vecs[i].rr;  tb_rdata[0] = vecs[i].rd;
         tick();
         check($sformatf("vector %0d", i), sample(0), vecs[i].exp);
      end
      cmd_valid[0] = 1'b0;
      rsp_ready[0] = 1'b1;

      // Registered read: strobe held three cycles, only the last data counts.
      rsp_ready[1] = 1'b0;
      re_first = -1;  rv_first = -1;  re_cycles = 0;
      push_cmd(1, 1'b1, 33'h3C, 33'h0);
      for (int c = 0; c < 20 && rv_first < 0; c++) begin
         if (read_enable[1]) begin
            re_cycles++;
            if (re_first < 0) re_first = c;
         end
         if (rsp_valid[1]) rv_first = c;
         tb_rdata[1] = (read_enable[1] && re_cycles == 3) ? 21'h1F00F : 21'(c * 37 + 5);
         tick();
      end
      check("lat2 accept to strobe", 128'(re_first), 128'(1));
      check("lat2 read_enable cycles", 128'(re_cycles), 128'(3));
      check("lat2 strobe to rsp_valid", 128'(rv_first - re_first), 128'(3));
      check("lat2 rsp fields", {rsp_addr[1], rsp_rdata[1]}, {33'h3C, 21'h1F00F});
      rsp_ready[1] = 1'b1;
      tick();
      check("lat2 rsp taken", 128'(rsp_valid[1]), 128'(0));

      // Back-pressure: a write queued behind a stalled read waits for acceptance.
      rsp_ready[1] = 1'b0;
      tb_rdata[1]  = 21'h0F0F0;
      push_cmd(1, 1'b1, 33'h10, 33'h0);
      push_cmd(1, 1'b0, 33'h20, 33'hBEEF);
      wait_rsp(1, "backpressure");
      check("backpressure rsp fields", {rsp_addr[1], rsp_rdata[1]}, {33'h10, 21'h0F0F0});
      snap = sample(1);
      for (int c = 0; c < 5; c++) begin
         tb_rdata[1] = 21'(c + 1);
         tick();
         check($sformatf("backpressure hold %0d", c), sample(1), snap);
      end
      rsp_ready[1] = 1'b1;
      tick();
      check("write after accept", {rsp_valid[1], write_enable[1], address[1], write_data[1]},
            {1'b0, 1'b1, 33'h20, 33'hBEEF});
      tick();
      check("write burst end", {write_enable[1], busy[1]}, 128'(0));

      // Full FIFO behind a read stalled in RESP.
      rsp_ready[1] = 1'b0;
      push_cmd(1, 1'b1, 33'h30, 33'h0);
      wait_rsp(1, "full fifo");
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ready before push %0d", i), 128'(cmd_ready[1]), 128'(1));
         push_cmd(1, 1'b0, 33'h40 + 33'(i), 33'(i));
         check($sformatf("level after push %0d", i), 128'(cmd_level[1]), 128'(i + 1));
      end
      check("ready low when full", 128'(cmd_ready[1]), 128'(0));
      push_cmd(1, 1'b0, 33'h44, 33'h4);
      check("fifth push refused", 128'(cmd_level[1]), 128'(4));
      rsp_ready[1] = 1'b1;
      tick();
      check("ready on first pop", {cmd_ready[1], cmd_level[1], write_enable[1], address[1]},
            {1'b1, 3'd3, 1'b1, 33'h40});
      wait_idle(1, "full fifo");

      // Reset while the registered read is waiting for data.
      push_cmd(1, 1'b1, 33'h50, 33'h0);
      push_cmd(1, 1'b0, 33'h60, 33'h7);
      check("read strobe before reset", 128'(read_enable[1]), 128'(1));
      tick();
      check("read held in wait", 128'(read_enable[1]), 128'(1));
      #2 reset = 1'b0;
      #1 check("strobes drop on reset", {read_enable[1], write_enable[1]}, 128'(0));
      tick();
      reset = 1'b1;
      check("state after reset", {cmd_level[1], rsp_valid[1], busy[1], cmd_ready[1]},
            {3'd0, 1'b0, 1'b0, 1'b1});
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("no stale strobe %0d", c), {read_enable[1], write_enable[1], busy[1]}, 128'(0));
      end

      auto_rsp = 1'b1;
      run_random(0, 400);
      run_random(1, 400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_bus_master.md
# register_bus_master

Initiator for the on-chip register W/R bus: it drives `address`, `write_enable`, `write_data` and `read_enable` into register responders such as the pipe-enable controlling registers, and captures their `read_data`. Software or sequencer logic pushes register commands through a valid/ready port into a small command FIFO. A control FSM issues each command on the bus and returns read results through a valid/ready response port. Read sampling delay is programmable, so the block serves both combinational-read and registered-read responders.

## Interface
- `ADDR_WIDTH`, 33: bus address width.
- `WDATA_WIDTH`, 33: write data width.
- `RDATA_WIDTH`, 21: read data width.
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `READ_LATENCY`, 0: extra cycles `read_enable` is held before `read_data` is sampled (0 to 7).
- Reset is `reset`, asynchronous, active-low. Clock is `clock`.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO not full, equal to `!full`.
- `cmd_is_read` in 1: 1 = read, 0 = write.
- `cmd_addr` in ADDR_WIDTH: target address.
- `cmd_wdata` in WDATA_WIDTH: write payload; ignored for reads.
- `rsp_valid` out 1: read result present.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_addr` out ADDR_WIDTH: address of the read.
- `rsp_rdata` out RDATA_WIDTH: captured read data.
- `address` out ADDR_WIDTH: bus address, registered.
- `write_enable` out 1: bus write strobe, registered.
- `write_data` out WDATA_WIDTH: bus write data, registered.
- `read_enable` out 1: bus read strobe, registered.
- `read_data` in RDATA_WIDTH: responder read data.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `cmd_level` out clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- **Command acceptance:** a command is accepted on a rising edge with `cmd_valid && cmd_ready`. There is no bypass path; the FIFO head is usable from the next cycle.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head, load `address`/`write_data`, set `write_enable` or `read_enable` accordingly, and go to ISSUE.
- **ISSUE, write:** `write_enable` is high for exactly this cycle. If the FIFO is non-empty, pop and reload the bus registers, staying in ISSUE (back-to-back issue, one command per cycle). Otherwise clear the strobes and go to IDLE.
- **ISSUE, read:**
  - With `READ_LATENCY` = 0: capture `read_data` into `rsp_rdata` and `address` into `rsp_addr` at the end of the cycle, drop `read_enable`, go to RESP.
  - Otherwise, load the latency counter with `READ_LATENCY` and go to WAIT.
- **WAIT:** `read_enable` and `address` are held. Decrement the counter. When it reaches 0, capture `read_data` at the end of that cycle, drop `read_enable`, go to RESP.
- **RESP:** `rsp_valid` = 1. On `rsp_ready`, go to IDLE, or pop the next command directly into ISSUE if the FIFO is non-empty. Commands are never reordered; a write queued behind a read waits for the read response to be taken.
- **Idle bus values:** after any strobe, `address` and `write_data` hold their last values. Only the strobes return to 0.
- **Exclusivity:** `write_enable` and `read_enable` are never high in the same cycle.
- **Widths:** `cmd_level` increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop. FIFO pointers wrap modulo `FIFO_DEPTH`.
- **Full FIFO:** `cmd_ready` = 0. A push in the same cycle as a pop is not possible while full, because ready is already low.

## Timing
- **Reset values:** all outputs are 0 except `cmd_ready` = 1. FIFO is empty, FSM is IDLE, counter is 0.
- **Reset mid-operation:** strobes drop asynchronously, the FIFO is flushed, and any pending response is discarded. No bus strobe is issued in the first cycle after reset release.
- **Accept to strobe:** a command accepted at edge k into an empty, idle block asserts its strobe in the cycle after edge k+1, i.e. 2 cycles of latency.
- **Read to response:** `rsp_valid` rises 1 + `READ_LATENCY` cycles after `read_enable` rises.
- **Throughput:** a burst of N writes occupies N consecutive strobe cycles. Each read costs 2 + `READ_LATENCY` cycles plus response back-pressure.
- **Response stability:** `rsp_valid`, `rsp_addr` and `rsp_rdata` remain stable until accepted.

## Structure
- **Package `register_bus_pkg`:**
  - FSM state enum (IDLE/ISSUE/WAIT/RESP).
  - Op encoding constants (OP_WRITE = 0, OP_READ = 1).
  - Default width constants (33/33/21).
  - Packed command struct {is_read, addr, wdata}.
- **Sub-module `register_bus_cmd_fifo`:**
  - Synchronous FIFO, parameterised on depth and packed command width.
  - Provides `full`, `empty` and `level`.
  - Async active-low reset.

## Test plan
- **Write burst:** push writes 0xAA/data 0x1234 and 0x55/data 0x1 on back-to-back cycles → two consecutive `write_enable` cycles with matching `address`/`write_data`; `read_enable` stays 0; `cmd_level` returns to 0; `busy` falls.
- **Combinational read (`READ_LATENCY` = 0):** responder returns 0x00ABC at address 0xAA → `read_enable` high for 1 cycle; `rsp_valid` with `rsp_addr` = 0xAA and `rsp_rdata` = 0x00ABC the next cycle.
- **Registered read (`READ_LATENCY` = 2):** → `read_enable` high for 3 cycles; data sampled on the third cycle; values driven earlier are ignored.
- **Back-pressure:** hold `rsp_ready` = 0 for 5 cycles with a queued write behind the read → response stable throughout; the write strobe appears only after acceptance.
- **Full FIFO:** push 5 commands with depth 4 while the FSM is stalled in RESP → `cmd_ready` = 0 after 4 pushes (the stalled read already popped, so `cmd_level` = 4); ready reasserts on the first pop.
- **Reset mid-read:** assert `reset` during WAIT → strobes drop immediately; after release, `cmd_level` = 0, `rsp_valid` = 0, and no stale strobe appears.
